riscv_run_checker: RTL

//  Synthesizable self-checking run controller for the RISC-V core.
//  - Sequences the core's reset, lets the core run for a bounded number of cycles, then reads
//    the register file through a read port and compares each entry against an expected table.
//  - Reports pass/fail, mismatch count, first failing index and cycles run.
//  - Sits beside top_level, in simulation benches and in FPGA bring-up.

---
 rtl/riscv_run_checker.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/riscv_run_checker.sv
// Run controller: holds the core in reset, lets it run for a bounded time, then walks the
// register file against a programmable expected table. Optional halt input via RUN_HALT_EN.
module riscv_run_checker #(
  parameter  int XLEN       = 32,
  parameter  int NUM_REGS   = 32,
  parameter  int RST_CYCLES = 2,
  parameter  int RUN_CYCLES = 15,
  parameter  int CNT_W      = 16,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_idx,
  input  logic [XLEN-1:0] cfg_val,
  input  logic            cfg_chk,
  output logic            core_rst,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
`ifdef RUN_HALT_EN
  input  logic            halt,
`endif
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [AW:0]     err_cnt,
  output logic [AW-1:0]   first_err,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {IDLE, RESET_HOLD, RUN, CHECK, DONE} state_e;

  state_e             state_q;
  logic [31:0]        ph_q;
  logic               core_rst_q, busy_q, done_q, first_seen_q;
  logic [AW-1:0]      rf_raddr_q, first_err_q;
  logic [AW:0]        err_cnt_q;
  logic [CNT_W-1:0]   cycles_q;
  logic [XLEN-1:0]    exp_q [NUM_REGS];
  logic [NUM_REGS-1:0] chk_q;

  logic          idle_like, cfg_ok, run_last, run_end, timeout, mism;
  logic [AW-1:0] cmp_idx;

  always_comb begin
    idle_like = (state_q == IDLE) || (state_q == DONE);
    cfg_ok    = cfg_we && idle_like && ({1'b0, cfg_idx} < (AW+1)'(NUM_REGS));
    run_last  = (ph_q == 32'(RUN_CYCLES - 1));
`ifdef RUN_HALT_EN
    run_end   = halt || run_last;
    timeout   = run_last && !halt;
`else
    run_end   = run_last;
    timeout   = 1'b0;
`endif
    // read data in CHECK phase k belongs to the address issued in phase k-1
    cmp_idx   = AW'(ph_q - 32'd1);
    mism      = (state_q == CHECK) && (ph_q != '0) && chk_q[cmp_idx] &&
                (rf_rdata != exp_q[cmp_idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= '0;
    else if (cfg_ok) chk_q[cfg_idx] <= cfg_chk;
  end

  always_ff @(posedge clk) begin
    if (cfg_ok) exp_q[cfg_idx] <= cfg_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ph_q         <= '0;
      core_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rf_raddr_q   <= '0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
      first_seen_q <= 1'b0;
      cycles_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= RESET_HOLD;
            ph_q         <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_cnt_q    <= '0;
            first_err_q  <= '0;
            first_seen_q <= 1'b0;
            cycles_q     <= '0;
          end
        end
        RESET_HOLD: begin
          if (ph_q == 32'(RST_CYCLES - 1)) begin
            state_q    <= RUN;
            ph_q       <= '0;
            core_rst_q <= 1'b0;
          end else begin
            ph_q <= ph_q + 32'd1;
          end
        end
        RUN: begin
          if (cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
          ph_q <= ph_q + 32'd1;
          if (run_end) begin
            state_q    <= CHECK;
            ph_q       <= '0;
            core_rst_q <= 1'b1;
            rf_raddr_q <= '0;
            if (timeout && (err_cnt_q == '0)) err_cnt_q <= (AW+1)'(1);
          end
        end
        CHECK: begin
          ph_q <= ph_q + 32'd1;
          if (ph_q < 32'(NUM_REGS - 1)) rf_raddr_q <= rf_raddr_q + AW'(1);
          if (mism) begin
            if (err_cnt_q != (AW+1)'(NUM_REGS)) err_cnt_q <= err_cnt_q + (AW+1)'(1);
            if (!first_seen_q) begin
              first_seen_q <= 1'b1;
              first_err_q  <= cmp_idx;
            end
          end
          if (ph_q == 32'(NUM_REGS)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_rst  = core_rst_q;
  assign rf_raddr  = rf_raddr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (err_cnt_q == '0);
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;
  assign cycles    = cycles_q;

endmodule
